// File: rtl/arith_unit.sv
// arith_unit: registered 16-bit unsigned add/sub/mul/div selected by op_sel.
// Divide by zero saturates to all ones.
module arith_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    input  logic [1:0]       op_sel,
    output logic [WIDTH-1:0] data_out
);
    logic [WIDTH-1:0] result;
    always_comb begin
        result = op_sel == 2'b00 ? data_1 + data_2 :
                 op_sel == 2'b01 ? data_1 - data_2 :
                 op_sel == 2'b10 ? data_1 * data_2 :
                 data_2 == '0    ? '1 : data_1 / data_2;
    end
    always_ff @(posedge clk) begin
        if (reset) data_out <= '0;
        else       data_out <= result;
    end
endmodule

// File: tb/tb_arith_unit.sv
// tb_arith_unit: directed vectors with hand-computed results for arith_unit.
module tb_arith_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_1, data_2, data_out;
    logic [1:0]  op_sel;
    int errors = 0;
    int checks = 0;

    arith_unit dut (
        .clk(clk), .reset(reset), .data_1(data_1), .data_2(data_2),
        .op_sel(op_sel), .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] exp);
        checks++;
        assert (data_out === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, data_out, exp);
        end
    endtask

    task automatic step(input logic r, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op, input string tag, input logic [15:0] exp);
        reset = r; data_1 = a; data_2 = b; op_sel = op;
        @(posedge clk);
        #1 check(tag, exp);
    endtask

    initial begin
        step(1'b1, 16'd7, 16'd4, 2'b00, "reset", 16'd0);
        step(1'b0, 16'd7, 16'd4, 2'b00, "post_reset_add", 16'd11);
        step(1'b0, 16'd9, 16'd8, 2'b00, "add", 16'd17);
        step(1'b0, 16'd65535, 16'd1, 2'b00, "add_wrap", 16'd0);
        step(1'b0, 16'd9, 16'd3, 2'b01, "sub", 16'd6);
        step(1'b0, 16'd3, 16'd5, 2'b01, "sub_wrap", 16'hFFFE);
        step(1'b0, 16'd9, 16'd7, 2'b10, "mul", 16'd63);
        step(1'b0, 16'd0, 16'd5, 2'b10, "mul_zero", 16'd0);
        step(1'b0, 16'd300, 16'd300, 2'b10, "mul_trunc", 16'd24464);
        step(1'b0, 16'd9, 16'd2, 2'b11, "div", 16'd4);
        step(1'b0, 16'd8, 16'd8, 2'b11, "div_equal", 16'd1);
        step(1'b0, 16'd0, 16'd3, 2'b11, "div_zero_num", 16'd0);
        step(1'b0, 16'd5, 16'd0, 2'b11, "div_by_zero", 16'hFFFF);
        step(1'b0, 16'd5, 16'd0, 2'b11, "hold_const", 16'hFFFF);
        // Inputs changed between edges must not reach data_out before the edge.
        data_1 = 16'd6; data_2 = 16'd3; op_sel = 2'b00;
        #2 check("no_early_update", 16'hFFFF);
        step(1'b0, 16'd6, 16'd3, 2'b00, "b2b_add", 16'd9);
        step(1'b0, 16'd6, 16'd3, 2'b01, "b2b_sub", 16'd3);
        step(1'b0, 16'd6, 16'd3, 2'b10, "b2b_mul", 16'd18);
        step(1'b0, 16'd6, 16'd3, 2'b11, "b2b_div", 16'd2);
        step(1'b1, 16'd9, 16'd9, 2'b10, "reset_priority", 16'd0);
        step(1'b0, 16'd9, 16'd9, 2'b10, "resume_mul", 16'd81);
        step(1'b0, 16'd65535, 16'd65535, 2'b10, "mul_max", 16'd1);
        step(1'b0, 16'd65535, 16'd1, 2'b11, "div_max", 16'd65535);
        step(1'b0, 16'd0, 16'd65535, 2'b01, "sub_max", 16'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/arith_unit.md
Name: arith_unit

Overview:
- Registered 16-bit arithmetic unit.
- Each clock it computes one of four unsigned operations on two operands, selected by a 2-bit opcode, and registers the result.
- Sits as a simple datapath leaf; the operands and opcode come from upstream control, and the registered result feeds downstream logic.

Parameters:
- WIDTH, 16, operand and result width in bits. All behaviour below is stated for 16; any other value scales identically.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_1  input  16  operand A, unsigned.
- data_2  input  16  operand B, unsigned.
- op_sel  input  2  operation select.
- data_out  output  16  registered result, unsigned.

Behaviour:
- Single clock domain. The only state is the data_out register.
- Reset:
  - reset is synchronous and active-high, sampled on the rising edge of clk.
  - When reset=1 at a clk edge, data_out becomes 16'h0000, regardless of op_sel and the operands.
  - Reset has priority over computation.
  - Asserting reset mid-stream discards the pending result; no other state exists.
- Normal operation (reset=0): on each rising edge, data_out is loaded with f(data_1, data_2, op_sel), computed combinationally from the values present just before the edge.
- op_sel encoding, all operations unsigned:
  - 2'b00: add. data_out = (data_1 + data_2) mod 2^16; the carry-out is discarded.
  - 2'b01: subtract. data_out = (data_1 - data_2) mod 2^16; wraps two's-complement when data_2 > data_1 (e.g. 3-5 = 16'hFFFE).
  - 2'b10: multiply. data_out = low 16 bits of the 32-bit product data_1*data_2; the upper 16 bits are discarded.
  - 2'b11: divide. data_out = floor(data_1 / data_2), the unsigned integer quotient.
- Divide by zero: when data_2 = 0 with op_sel = 2'b11, data_out = 16'hFFFF. No exception or flag is raised.
- Latency and throughput:
  - Exactly one cycle: inputs presented before edge N appear on data_out after edge N.
  - A new operation is accepted every cycle.
  - There is no handshake and no valid signal.
- Holding: data_out updates every cycle while reset=0. With constant inputs, data_out stays constant.
- Operand or op_sel changes between edges have no effect until the next edge.
- No X propagation requirements beyond standard simulation; the output must never be X after the first reset edge.
- Implementation: one combinational result mux feeding the 16-bit register. Division may be a single-cycle combinational divider, provided latency stays at one cycle.

Test Plan:
- Reset: drive data_1=7, data_2=4, op_sel=0 and assert reset for one edge -> data_out=0. Deassert reset -> data_out=11 after the next edge.
- Add/subtract: 9+8 -> 17. 65535+1 -> 0 (wrap). Sub 9-3 -> 6. Sub 3-5 -> 65534 (16'hFFFE).
- Multiply: 9*7 -> 63. 0*5 -> 0. 300*300 -> 90000 mod 65536 = 24464.
- Divide: 9/2 -> 4. 8/8 -> 1. 0/3 -> 0. 5/0 -> 65535 (16'hFFFF).
- Latency and back-to-back: change op_sel 0,1,2,3 on consecutive cycles with data_1=6, data_2=3 -> data_out sequence 9, 3, 18, 2, each one cycle after its inputs.
- Reset priority: assert reset mid-sequence with op_sel=2, data_1=9, data_2=9 -> data_out=0 on that edge, not 81. Resume after deassertion -> 81 on the following edge.
